// File: rtl/ramb16_ctrl_pkg.sv
// rtl/ramb16_ctrl_pkg.sv - shared geometry, word type and FSM states for the RAMB16 port-A sequencer
package ramb16_ctrl_pkg;
  localparam int RAM_DEPTH = 512;
  localparam int RAM_AW    = 9;
  localparam int RAM_DW    = 32;
  localparam int RAM_PW    = 4;
  localparam int RAM_WW    = RAM_DW + RAM_PW;

  typedef logic [RAM_WW-1:0] ram_word_t;

  typedef enum logic {
    ST_INIT,
    ST_ARB
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting the search at ptr_i
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    if (en_i) begin
      for (int k = 0; k < NREQ; k++) begin
        j = int'(ptr_i) + k;
        if (j >= NREQ) j = j - NREQ;
        jj = IW'(j);
        if (!found && req_i[jj]) begin
          found     = 1'b1;
          gnt_o[jj] = 1'b1;
          idx_o     = jj;
        end
      end
    end
    any_o = found;
  end
endmodule

// File: rtl/ramb16_s36_port_arb.sv
// rtl/ramb16_s36_port_arb.sv - clears a RAMB16_S36 port A after reset, then shares it round-robin
module ramb16_s36_port_arb
  import ramb16_ctrl_pkg::*;
#(
  parameter int          NREQ      = 2,
  parameter logic [35:0] INIT_WORD = 36'h0,
  parameter bit          SKIP_INIT = 1'b0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ_VALID,
  output logic [NREQ-1:0]    REQ_READY,
  input  logic [NREQ-1:0]    REQ_WE,
  input  logic [NREQ*9-1:0]  REQ_ADDR,
  input  logic [NREQ*36-1:0] REQ_DI,
  output logic [NREQ-1:0]    RSP_VALID,
  output logic [35:0]        RSP_DO,
  output logic               INIT_DONE,
  output logic               RAM_EN,
  output logic               RAM_WE,
  output logic               RAM_SSR,
  output logic [8:0]         RAM_ADDR,
  output logic [31:0]        RAM_DI,
  output logic [3:0]         RAM_DIP,
  input  logic [31:0]        RAM_DO,
  input  logic [3:0]         RAM_DOP
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] cnt_q, cnt_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              tag_vld_q, tag_vld_d;
  logic [IW-1:0]     tag_idx_q, tag_idx_d;
  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic              arb_en;
  ram_word_t         wr_word;

  // RST masks grants immediately so nothing is accepted that the reset edge would then discard.
  assign arb_en = (state_q == ST_ARB) && !RST;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i (REQ_VALID),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    tag_vld_d = 1'b0;
    tag_idx_d = tag_idx_q;
    REQ_READY = '0;
    RAM_EN    = 1'b0;
    RAM_WE    = 1'b0;
    RAM_ADDR  = '0;
    wr_word   = '0;
    if (!RST) begin
      case (state_q)
        ST_INIT: begin
          RAM_EN   = 1'b1;
          RAM_WE   = 1'b1;
          RAM_ADDR = cnt_q;
          wr_word  = INIT_WORD;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == RAM_AW'(RAM_DEPTH - 1)) state_d = ST_ARB;
        end
        ST_ARB: begin
          REQ_READY = gnt;
          if (gnt_any) begin
            RAM_EN    = 1'b1;
            RAM_WE    = REQ_WE[gnt_idx];
            RAM_ADDR  = REQ_ADDR[int'(gnt_idx)*RAM_AW +: RAM_AW];
            wr_word   = REQ_DI[int'(gnt_idx)*RAM_WW +: RAM_WW];
            ptr_d     = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            tag_vld_d = !REQ_WE[gnt_idx];
            tag_idx_d = gnt_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= SKIP_INIT ? ST_ARB : ST_INIT;
      cnt_q     <= '0;
      ptr_q     <= '0;
      tag_vld_q <= 1'b0;
      tag_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
    end
  end

  always_comb begin
    RSP_VALID = '0;
    if (tag_vld_q && !RST) RSP_VALID[tag_idx_q] = 1'b1;
  end

  assign RSP_DO    = {RAM_DOP, RAM_DO};
  assign INIT_DONE = (state_q == ST_ARB) && !RST;
  assign RAM_SSR   = 1'b0;
  assign RAM_DI    = wr_word[RAM_DW-1:0];
  assign RAM_DIP   = wr_word[RAM_WW-1:RAM_DW];
endmodule

// File: tb/tb_ramb16_s36_port_arb.sv
// tb/tb_ramb16_s36_port_arb.sv - scoreboard bench for the RAMB16 port-A sequencer
module tb_ramb16_s36_port_arb;
  localparam int          NREQ      = 2;
  localparam logic [35:0] IWORD     = 36'h5A5A5A5A5;
  localparam logic [35:0] SKIP_WORD = 36'h123456789;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [NREQ*9-1:0] req_addr = '0;
  logic [NREQ*36-1:0] req_di = '0;
  logic [35:0]       rsp_do;
  logic              init_done, ram_en, ram_we, ram_ssr;
  logic [8:0]        ram_addr;
  logic [31:0]       ram_di, ram_do;
  logic [3:0]        ram_dip, ram_dop;
  logic [35:0]       mem [512];
  logic [35:0]       do_q;

  ramb16_s36_port_arb #(.NREQ(NREQ), .INIT_WORD(IWORD), .SKIP_INIT(1'b0)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_DI(req_di), .RSP_VALID(rsp_valid), .RSP_DO(rsp_do),
    .INIT_DONE(init_done), .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_SSR(ram_ssr),
    .RAM_ADDR(ram_addr), .RAM_DI(ram_di), .RAM_DIP(ram_dip), .RAM_DO(ram_do), .RAM_DOP(ram_dop)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= {ram_dip, ram_di};
      else        do_q <= mem[ram_addr];
    end
  end
  assign ram_do  = do_q[31:0];
  assign ram_dop = do_q[35:32];

  logic              rst_b = 1'b1;
  logic [NREQ-1:0]   req_valid_b = '0, req_we_b = '0, req_ready_b, rsp_valid_b;
  logic [NREQ*9-1:0] req_addr_b = '0;
  logic [NREQ*36-1:0] req_di_b = '0;
  logic [35:0]       rsp_do_b;
  logic              init_done_b, ram_en_b, ram_we_b, ram_ssr_b;
  logic [8:0]        ram_addr_b;
  logic [31:0]       ram_di_b, ram_do_b;
  logic [3:0]        ram_dip_b, ram_dop_b;
  logic [35:0]       mem_b [512];
  logic [35:0]       do_b;

  ramb16_s36_port_arb #(.NREQ(NREQ), .INIT_WORD(36'h0), .SKIP_INIT(1'b1)) dut_skip (
    .CLK(clk), .RST(rst_b), .REQ_VALID(req_valid_b), .REQ_READY(req_ready_b), .REQ_WE(req_we_b),
    .REQ_ADDR(req_addr_b), .REQ_DI(req_di_b), .RSP_VALID(rsp_valid_b), .RSP_DO(rsp_do_b),
    .INIT_DONE(init_done_b), .RAM_EN(ram_en_b), .RAM_WE(ram_we_b), .RAM_SSR(ram_ssr_b),
    .RAM_ADDR(ram_addr_b), .RAM_DI(ram_di_b), .RAM_DIP(ram_dip_b), .RAM_DO(ram_do_b), .RAM_DOP(ram_dop_b)
  );

  always @(posedge clk) begin
    if (ram_en_b) begin
      if (ram_we_b) mem_b[ram_addr_b] <= {ram_dip_b, ram_di_b};
      else          do_b <= mem_b[ram_addr_b];
    end else if (rst_b) begin
      mem_b[0] <= SKIP_WORD;
    end
  end
  assign ram_do_b  = do_b[31:0];
  assign ram_dop_b = do_b[35:32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          idx;
    logic [35:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [35:0] ref_mem [512];
  int          grant_log[$];
  int          ptr_m = 0;
  bit          in_init = 1'b1;
  int          init_cnt = 0;
  int          we_cycles = 0;
  int          g, j, a;
  exp_t        e;

  // Monitor: expected behaviour derived from the arbitration/latency rules, independent of the driver.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_ssr", ram_ssr, 0);
      sb.delete();
      ptr_m = 0;
      in_init = 1'b1;
      init_cnt = 0;
      we_cycles = 0;
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, 64'(1) << e.idx);
        chk("rsp_do", rsp_do, e.data);
      end else begin
        chk("rsp_idle", rsp_valid, 0);
      end
      if (in_init) begin
        chk("init_ready", req_ready, 0);
        chk("init_done_low", init_done, 0);
        chk("init_en", ram_en, 1);
        chk("init_we", ram_we, 1);
        chk("init_addr", ram_addr, init_cnt);
        chk("init_data", {ram_dip, ram_di}, IWORD);
        if (ram_we) we_cycles++;
        ref_mem[init_cnt] = IWORD;
        init_cnt++;
        if (init_cnt == 512) in_init = 1'b0;
      end else begin
        chk("init_done_high", init_done, 1);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          j = (ptr_m + k) % NREQ;
          if (g < 0 && req_valid[j]) g = j;
        end
        if (g < 0) begin
          chk("idle_ready", req_ready, 0);
          chk("idle_en", ram_en, 0);
        end else begin
          a = int'(req_addr[g*9 +: 9]);
          chk("grant", req_ready, 64'(1) << g);
          chk("gnt_en", ram_en, 1);
          chk("gnt_we", ram_we, req_we[g]);
          chk("gnt_addr", ram_addr, a);
          chk("gnt_data", {ram_dip, ram_di}, req_di[g*36 +: 36]);
          if (req_we[g]) ref_mem[a] = req_di[g*36 +: 36];
          else           sb.push_back('{g, ref_mem[a], cyc + 1});
          ptr_m = (g + 1) % NREQ;
          grant_log.push_back(g);
        end
      end
    end
  end

  task automatic issue(input int i, input bit we, input logic [8:0] ad, input logic [35:0] d);
    int n;
    n = 0;
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*9 +: 9] = ad;
    req_di[i*36 +: 36] = d;
    @(negedge clk);
    while (!req_ready[i] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("issue_accept", req_ready[i], 1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, g0;
    logic [1:0]  acc;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    n = 0;
    @(negedge clk);
    while (!init_done && n < 600) begin
      n++;
      @(negedge clk);
    end
    chk("init_len", n, 512);
    chk("init_we_cycles", we_cycles, 512);
    chk("portb_1ff", mem[9'h1FF], IWORD);
    @(posedge clk);
    #1;

    issue(0, 1'b1, 9'h0A3, 36'hF_DEADBEEF);
    issue(0, 1'b0, 9'h0A3, 36'h0);
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_rsp_do", rsp_do, 36'hF_DEADBEEF);
    @(posedge clk);
    #1;

    issue(0, 1'b1, 9'h010, {4'h3, 32'($urandom)});
    issue(1, 1'b1, 9'h020, {4'hC, 32'($urandom)});
    req_we = 2'b00;
    req_addr = {9'h020, 9'h010};
    g0 = grant_log.size();
    req_valid = 2'b11;
    repeat (6) @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("fair_count", grant_log.size() - g0, 6);
    chk("fair_first", grant_log[g0], 0);
    for (int k = 1; k < 6; k++) chk("fair_alternate", grant_log[g0 + k], 1 - grant_log[g0 + k - 1]);

    issue(0, 1'b0, 9'h000, 36'h0);
    req_we = 2'b10;
    req_addr = {9'h044, 9'h044};
    req_di = {36'h1_00000044, 36'h0};
    req_valid = 2'b11;
    @(negedge clk);
    chk("order_first", req_ready, 2'b10);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("order_second", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("order_rsp_valid", rsp_valid, 2'b01);
    chk("order_rsp_do", rsp_do, 36'h1_00000044);
    @(posedge clk);
    #1;

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          req_we[i] = 1'($urandom_range(0, 1));
          req_addr[i*9 +: 9] = 9'($urandom_range(0, 15));
          req_di[i*36 +: 36] = {4'($urandom), 32'($urandom)};
        end
      end
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (acc[i]) req_valid[i] = 1'b0;
    end
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;

    issue(0, 1'b0, 9'h044, 36'h0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (!init_done && n < 600) begin
      n++;
      @(negedge clk);
    end
    chk("reinit_len", n, 512);
    @(posedge clk);
    #1;

    req_valid_b = 2'b01;
    req_we_b = 2'b00;
    req_addr_b = '0;
    @(negedge clk);
    chk("skip_rst_ready", req_ready_b, 0);
    chk("skip_rst_done", init_done_b, 0);
    chk("skip_rst_rsp", rsp_valid_b, 0);
    @(posedge clk);
    #1 rst_b = 1'b0;
    @(negedge clk);
    chk("skip_grant", req_ready_b, 2'b01);
    chk("skip_done", init_done_b, 1);
    chk("skip_ram_en", ram_en_b, 1);
    chk("skip_ram_addr", ram_addr_b, 0);
    @(posedge clk);
    #1 req_valid_b = 2'b00;
    @(negedge clk);
    chk("skip_rsp_valid", rsp_valid_b, 2'b01);
    chk("skip_rsp_do", rsp_do_b, SKIP_WORD);
    @(negedge clk);
    chk("skip_rsp_once", rsp_valid_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ramb16_s36_port_arb.md
Name: ramb16_s36_port_arb

Overview:
- Sequences and shares port A of a 512x36 dual-port block RAM (RAMB16_S36_S36) between NREQ requesters.
- After reset it clears every word to INIT_WORD, then grants one access per cycle by round-robin.
- Read data is returned to the owning requester with fixed 1-cycle latency.
- Port B of the RAM is untouched and remains free for a separate consumer.

Parameters:
- NREQ, 2, number of requesters (2..4).
- INIT_WORD, 36'h0, value written to all 512 words during the init sweep.
- SKIP_INIT, 0, if 1 skip the sweep and go straight to arbitration.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  NREQ  per-requester request valid.
- REQ_READY  out  NREQ  one-hot grant; a request is accepted when VALID and READY are both high.
- REQ_WE  in  NREQ  1 = write, 0 = read.
- REQ_ADDR  in  NREQ*9  packed word addresses; requester i uses [9i+8:9i].
- REQ_DI  in  NREQ*36  packed write data; {parity[3:0], data[31:0]} per requester.
- RSP_VALID  out  NREQ  read-data valid, one-hot, no backpressure.
- RSP_DO  out  36  read data {DOPA, DOA}; shared bus, qualified by RSP_VALID.
- INIT_DONE  out  1  high once the sweep completes; stays high until RST.
- RAM_EN, RAM_WE, RAM_SSR  out  1 each  to ENA, WEA, SSRA. RAM_SSR is tied 0.
- RAM_ADDR  out  9  to ADDRA.
- RAM_DI  out  32  to DIA.
- RAM_DIP  out  4  to DIPA.
- RAM_DO  in  32  from DOA.
- RAM_DOP  in  4  from DOPA.

Behaviour:
- Reset values: REQ_READY=0, RSP_VALID=0, INIT_DONE=0, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, round-robin pointer=0, read tag cleared.
- States: INIT, ARB. Reset enters INIT, or ARB when SKIP_INIT=1.
- INIT:
  - 9-bit counter; each cycle RAM_EN=1, RAM_WE=1, RAM_ADDR=count, data=INIT_WORD.
  - Counts 0..511, which takes exactly 512 cycles.
  - On count 511, move to ARB next cycle; INIT_DONE is registered high in the first ARB cycle.
  - REQ_READY=0 throughout INIT.
  - With SKIP_INIT=1, INIT_DONE rises in the first cycle after RST deasserts.
- ARB:
  - Grant is combinational. Starting at pointer p, the first i in p, p+1, ... (mod NREQ) with REQ_VALID[i]=1 gets REQ_READY[i]=1; all others get 0.
  - At most one grant per cycle. No valids means no grant and RAM_EN=0.
  - Granted request drives the RAM combinationally the same cycle: RAM_EN=1, RAM_WE=REQ_WE[i], RAM_ADDR and RAM_DI/DIP from requester i.
  - On a grant to i, pointer <= (i+1) mod NREQ; otherwise the pointer holds.
  - A requester that keeps VALID high is served within NREQ cycles.
- Read return:
  - An accepted read registers tag {valid, i}.
  - The next cycle, RSP_VALID[i]=1 and RSP_DO={RAM_DOP, RAM_DO}. Latency is exactly 1 cycle.
  - Back-to-back reads give one response per cycle, in order.
- Writes produce no response. Port A WRITE_MODE is independent of this block: for a write, RAM DO is ignored because the tag is not set.
- Same-address read and write from different requesters are serialized by grant order. A read granted after the write returns the new data.
- Cross-port (A vs B) collisions are outside this block's scope.
- RST asserted mid-operation (INIT or ARB), taking effect on the next edge:
  - All outputs return to reset values.
  - The pending read tag is dropped, so no RSP_VALID is issued for it.
  - The sweep restarts at address 0.
- Sender rule: REQ_* must be held stable while VALID is high and READY is low. This block does not check it.

Decomposition:
- Package ramb16_ctrl_pkg:
  - Constants RAM_DEPTH=512, RAM_AW=9, RAM_DW=32, RAM_PW=4, RAM_WW=36.
  - Type ram_word_t (36-bit).
  - State enum {ST_INIT, ST_ARB}.
- One sub-module, rr_arbiter:
  - Parameterized NREQ.
  - Takes request vector, pointer and advance-enable; outputs one-hot grant and index.
- Top level holds the FSM, init counter, read tag and RAM muxing.

Test Plan:
- Init sweep: RST 1 cycle, INIT_WORD=36'h5A5A5A5A5 -> RAM_WE high for exactly 512 cycles, addresses 0..511 in order, INIT_DONE high on cycle 513; a port-B readback of address 0x1FF gives 36'h5A5A5A5A5.
- Single write/read: after init, req0 writes 0x0A3 <= 36'hF_DEADBEEF, then reads 0x0A3 -> RSP_VALID[0] one cycle after the read grant, RSP_DO=36'hF_DEADBEEF, RSP_VALID[1] stays 0.
- Fairness: both requesters hold VALID reading addr 0x010 and 0x020 for 6 cycles -> grants alternate 0,1,0,1,0,1; responses alternate with matching data.
- Ordering: req1 writes 0x044 <= 36'h1_00000044 while req0 reads 0x044 in the same cycle with pointer=1 -> write granted first, read next cycle returns 36'h1_00000044.
- Reset mid-flight: read accepted, RST asserted on the next edge -> RSP_VALID stays 0, INIT restarts at address 0, INIT_DONE=0 until 512 cycles later.
- SKIP_INIT=1: RST then req0 read of 0x000 -> grant in the first cycle after reset, INIT_DONE=1, RSP_VALID[0] the next cycle.
